// File: rtl/ifa_pkg.sv
// ----------------------------------------------------------------------------
// ifa_pkg
//   Shared types and constants for the instruction-fetch arbiter.
//   - ifa_state_e : arbiter FSM state (2-bit encoding)
//   - IFA_NOP_INST: instruction returned when memory never answers
//   - WAY0 / WAY1 : way index constants used for owner and pointer values
// ----------------------------------------------------------------------------
package ifa_pkg;

    typedef enum logic [1:0] {
        IFA_IDLE = 2'd0,
        IFA_REQ  = 2'd1,
        IFA_WAIT = 2'd2
    } ifa_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] IFA_NOP_INST = 32'h0000_0013;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    // The way that is not 'w'; used for the round-robin pointer flip.
    function automatic logic ifa_other_way(input logic w);
        return (w == WAY0) ? WAY1 : WAY0;
    endfunction

endpackage

// File: rtl/inst_fetch_arbiter_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_arbiter_if
//   Bundles both way fetch handshakes and the single instruction-memory port.
//   Signal suffixes (_i/_o) are from the arbiter's point of view.
//
//   Handshake rules:
//     way:  wayN_request_i stays high with a stable wayN_instAddr_i until
//           wayN_dataOk_o pulses; wayN_inst_o/wayN_err_o are valid with that
//           pulse. wayN_flush_i abandons the outstanding fetch of that way.
//     mem:  mem_req_o holds with mem_addr_o until mem_gnt_i is seen high;
//           one mem_rvalid_i/mem_rdata_i follows at least one cycle later.
//
//   Modports:
//     slave  - the arbiter
//     master - fetch units plus the memory (the environment around the arbiter)
// ----------------------------------------------------------------------------
interface inst_fetch_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              way0_request_i;
    logic [ADDR_W-1:0] way0_instAddr_i;
    logic              way0_flush_i;
    logic [DATA_W-1:0] way0_inst_o;
    logic              way0_dataOk_o;
    logic              way0_err_o;

    logic              way1_request_i;
    logic [ADDR_W-1:0] way1_instAddr_i;
    logic              way1_flush_i;
    logic [DATA_W-1:0] way1_inst_o;
    logic              way1_dataOk_o;
    logic              way1_err_o;

    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  way0_request_i, way0_instAddr_i, way0_flush_i,
        output way0_inst_o, way0_dataOk_o, way0_err_o,
        input  way1_request_i, way1_instAddr_i, way1_flush_i,
        output way1_inst_o, way1_dataOk_o, way1_err_o,
        output mem_req_o, mem_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output way0_request_i, way0_instAddr_i, way0_flush_i,
        input  way0_inst_o, way0_dataOk_o, way0_err_o,
        output way1_request_i, way1_instAddr_i, way1_flush_i,
        input  way1_inst_o, way1_dataOk_o, way1_err_o,
        input  mem_req_o, mem_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/ifa_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ifa_rr_arbiter
//   Two-input round-robin grant. The pointer names the way that wins a tie;
//   it only moves when a memory transaction completes, and then points at the
//   way that did not own that transaction.
//
//   Ports:
//     clk, reset_n  clock, synchronous active-low reset (pointer -> WAY0)
//     req_i[1:0]    eligible requesters (bit index = way)
//     advance_i     transaction completed this cycle
//     owner_i       owner of the completing transaction
//     valid_o       at least one eligible requester
//     grant_o       winning way (meaningful when valid_o)
// ----------------------------------------------------------------------------
module ifa_rr_arbiter
    import ifa_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       owner_i,
    output logic       valid_o,
    output logic       grant_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = ifa_other_way(owner_i);
        end
    end

    always_comb begin
        valid_o = |req_i;
        grant_o = WAY0;
        if (req_i == 2'b11) begin
            grant_o = ptr_q;
        end else if (req_i[1]) begin
            grant_o = WAY1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= WAY0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/inst_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// inst_fetch_arbiter
//   Shares one instruction-memory port between the way0 and way1 fetch units.
//   One memory transaction is in flight at a time; ties are broken round-robin.
//   A way's flush abandons its outstanding fetch: before the grant the memory
//   request is withdrawn, after the grant the response is swallowed.
//   Memory that never answers yields NOP_INST with an error pulse.
//
//   Ports:
//     clk, reset_n  clock, synchronous active-low reset
//     bus           inst_fetch_arbiter_if.slave (way handshakes + memory port)
//     dbg_state_o   current FSM state
// ----------------------------------------------------------------------------
module inst_fetch_arbiter
    import ifa_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(IFA_NOP_INST)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    inst_fetch_arbiter_if.slave  bus,
    output ifa_state_e           dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT);

    ifa_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_req_q, mem_req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
    logic              ok0_q, ok0_d, ok1_q, ok1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic [1:0]        eligible;
    logic              arb_valid;
    logic              arb_grant;
    logic              advance;
    logic [ADDR_W-1:0] sel_addr;
    logic              owner_flush;
    logic              timeout;
    logic              deliver;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              unused_addr_lsbs;

    // A way whose dataOk is showing this cycle still has its old request up;
    // masking it stops the same fetch from being issued twice.
    assign eligible = {bus.way1_request_i & ~bus.way1_flush_i & ~ok1_q,
                       bus.way0_request_i & ~bus.way0_flush_i & ~ok0_q};

    assign sel_addr         = (arb_grant == WAY1) ? bus.way1_instAddr_i : bus.way0_instAddr_i;
    assign unused_addr_lsbs = ^sel_addr[1:0];
    assign owner_flush      = (owner_q == WAY1) ? bus.way1_flush_i : bus.way0_flush_i;
    assign timeout          = (cnt_q == CNT_W'(TIMEOUT - 1));

    ifa_rr_arbiter u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (eligible),
        .advance_i (advance),
        .owner_i   (owner_q),
        .valid_o   (arb_valid),
        .grant_o   (arb_grant)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        mem_req_d = mem_req_q;
        cnt_d     = '0;
        drop_d    = drop_q;
        inst0_d   = inst0_q;
        inst1_d   = inst1_q;
        ok0_d     = 1'b0;
        ok1_d     = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        advance   = 1'b0;
        deliver   = 1'b0;
        resp_data = NOP_INST;
        resp_err  = 1'b0;

        case (state_q)
            IFA_IDLE: begin
                drop_d = 1'b0;
                if (arb_valid) begin
                    owner_d   = arb_grant;
                    addr_d    = {sel_addr[ADDR_W-1:2], 2'b00};
                    mem_req_d = 1'b1;
                    state_d   = IFA_REQ;
                end
            end
            IFA_REQ: begin
                if (bus.mem_gnt_i) begin
                    // Memory has taken the request, so its response must be
                    // consumed even if the owner flushed in this same cycle.
                    mem_req_d = 1'b0;
                    drop_d    = owner_flush;
                    state_d   = IFA_WAIT;
                end else if (owner_flush) begin
                    mem_req_d = 1'b0;
                    state_d   = IFA_IDLE;
                end
            end
            IFA_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (owner_flush) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_rvalid_i || timeout) begin
                    advance   = 1'b1;
                    cnt_d     = '0;
                    drop_d    = 1'b0;
                    state_d   = IFA_IDLE;
                    // A flush arriving with the data still wins.
                    deliver   = !(drop_q || owner_flush);
                    resp_data = bus.mem_rvalid_i ? bus.mem_rdata_i : NOP_INST;
                    resp_err  = !bus.mem_rvalid_i;
                end
            end
            default: begin
                state_d = IFA_IDLE;
            end
        endcase

        if (deliver) begin
            if (owner_q == WAY1) begin
                inst1_d = resp_data;
                ok1_d   = 1'b1;
                err1_d  = resp_err;
            end else begin
                inst0_d = resp_data;
                ok0_d   = 1'b1;
                err0_d  = resp_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IFA_IDLE;
            owner_q   <= WAY0;
            addr_q    <= '0;
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            inst0_q   <= '0;
            inst1_q   <= '0;
            ok0_q     <= 1'b0;
            ok1_q     <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            mem_req_q <= mem_req_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            inst0_q   <= inst0_d;
            inst1_q   <= inst1_d;
            ok0_q     <= ok0_d;
            ok1_q     <= ok1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign bus.mem_req_o     = mem_req_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.way0_inst_o   = inst0_q;
    assign bus.way0_dataOk_o = ok0_q;
    assign bus.way0_err_o    = err0_q;
    assign bus.way1_inst_o   = inst1_q;
    assign bus.way1_dataOk_o = ok1_q;
    assign bus.way1_err_o    = err1_q;
    assign dbg_state_o       = state_q;

endmodule
